lcd_bus_sched: RTL and testbench
================================

LCD_BUS_SCHED -- requirements
Module: lcd_bus_sched

Interface
REQ-001 The block SHALL have parameter SHORT_WAIT, default 0, idle cycles after a normal byte or nibble transfer (legal range 0..15).
REQ-002 The block SHALL have parameter LONG_WAIT, default 2, idle cycles after a clear or home command (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock (1 kHz nominal, 1 ms per cycle).
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 2 bits, per-requester transfer request, held high until its ack.
REQ-006 The block SHALL have port nib, input, 2 bits, per-requester flag: send din[7:4] only.
REQ-007 The block SHALL have port rs_in, input, 2 bits, per-requester register-select value.
REQ-008 The block SHALL have ports din0 and din1, input, 8 bits each, byte from requester 0 and requester 1.
REQ-009 The block SHALL have port ack, output, 2 bits, one-cycle grant pulse per requester.
REQ-010 The block SHALL have port en, output, 1 bit, LCD enable strobe.
REQ-011 The block SHALL have port rs, output, 1 bit, LCD register select.
REQ-012 The block SHALL have port data, output, 4 bits, LCD data nibble.
REQ-013 The block SHALL have port busy, output, 1 bit, high in every state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, HI, HI_L, LO, LO_L and WAIT, all outputs registered.
REQ-015 In IDLE, at a clock edge with any req bit high, the block SHALL latch the winner's byte, rs_in and nib, pulse ack[winner] for exactly the next cycle, and enter HI.
REQ-016 In HI the block SHALL drive en=1, data=byte[7:4] and rs=latched rs, then go to HI_L.
REQ-017 In HI_L the block SHALL drive en=0, hold data and rs, then go to LO; if nib was latched, it SHALL instead go to WAIT, or to IDLE when the wait is 0.
REQ-018 In LO the block SHALL drive en=1 and data=byte[3:0], then go to LO_L (en=0, data held), then go to WAIT, or to IDLE when the wait is 0.
REQ-019 The wait SHALL be LONG_WAIT when latched rs=0, nib=0 and byte is 0x01, 0x02 or 0x03; otherwise it SHALL be SHORT_WAIT.
REQ-020 WAIT SHALL hold en=0 for exactly the selected number of cycles using a 4-bit down-counter, then return to IDLE.
REQ-021 Minimum byte throughput SHALL be 5 cycles per byte and minimum nibble throughput 3 cycles; IDLE SHALL grant in the same cycle it is entered if req is high.
REQ-022 Arbitration SHALL be round-robin: with both req high, the block grants the requester not granted last; with one req high, it grants that requester.
REQ-023 req changes outside IDLE SHALL be ignored; latched byte, rs and nib SHALL stay stable for the whole transfer.
REQ-024 en SHALL never be high in two consecutive cycles, and data and rs SHALL change only in cycles where en rises.

Reset
REQ-025 While reset_n=0, the block SHALL force state IDLE, en=0, rs=0, data=0, ack=0, busy=0, wait counter 0, and last-grant=1, so that requester 0 wins the first tie.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer immediately (asynchronously), and no ack SHALL be reissued for it after release.

Configuration
REQ-027 With macro LCD_BUS_SCHED_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and the last-grant register SHALL be omitted.
REQ-028 Without LCD_BUS_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-022.

Verification
REQ-029 Reset release, req0=1, din0=0x28, rs_in0=0 -> ack0 pulse; en=1/0/1/0 with data 0x2,0x2,0x8,0x8; IDLE after 5 cycles.
REQ-030 req1=1, nib1=1, din1=0x30 -> single en pulse with data=0x3; busy for 2 cycles.
REQ-031 req0=1, din0=0x01, rs_in0=0, LONG_WAIT=2 -> LO_L followed by 2 WAIT cycles with en=0; same byte with rs_in0=1 -> no wait.
REQ-032 req0=req1=1 held continuously -> acks alternate 0,1,0,1 (round-robin build); with LCD_BUS_SCHED_FIXED_PRIO_EN defined -> ack0 only.
REQ-033 reset_n=0 asserted in LO -> en=0 and data=0 immediately; after release with req0 held -> fresh ack0 and the transfer restarts at HI.

Source files
------------

// File: rtl/lcd_bus_sched_if.sv
// Requester/LCD-side signal bundle for lcd_bus_sched.
interface lcd_bus_sched_if;
   logic [1:0] req;
   logic [1:0] nib;
   logic [1:0] rs_in;
   logic [7:0] din0;
   logic [7:0] din1;
   logic [1:0] ack;
   logic       en;
   logic       rs;
   logic [3:0] data;
   logic       busy;

   modport master (output req, nib, rs_in, din0, din1,
                   input  ack, en, rs, data, busy);
   modport slave  (input  req, nib, rs_in, din0, din1,
                   output ack, en, rs, data, busy);
endinterface

// File: rtl/lcd_bus_sched.sv
// Two-requester scheduler driving a 4-bit HD44780-style LCD bus.
// Optional macro LCD_BUS_SCHED_FIXED_PRIO_EN: requester 0 always wins ties.
module lcd_bus_sched #(
   parameter int SHORT_WAIT = 0,
   parameter int LONG_WAIT  = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   lcd_bus_sched_if.slave  bus
);
   localparam logic [3:0] SW = 4'(SHORT_WAIT);
   localparam logic [3:0] LW = 4'(LONG_WAIT);

   typedef enum logic [2:0] {IDLE, HI, HI_L, LO, LO_L, WAIT} state_t;

   state_t     state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       rsl_q, rsl_d;
   logic       nib_q, nib_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] ack_q, ack_d;
   logic       en_q, en_d;
   logic       rs_q, rs_d;
   logic [3:0] data_q, data_d;
   logic       busy_q, busy_d;
   logic       win;
   logic [7:0] win_byte;
   logic [3:0] wait_n;

`ifdef LCD_BUS_SCHED_FIXED_PRIO_EN
   assign win = ~bus.req[0];
`else
   logic last_q, last_d;
   // On a tie, hand the bus to whoever did not get it last.
   assign win = (&bus.req) ? ~last_q : ~bus.req[0];
`endif

   assign win_byte = win ? bus.din1 : bus.din0;
   // Clear (0x01) and home (0x02/0x03) need the long settle time.
   assign wait_n = (!rsl_q && !nib_q &&
                    (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03)) ? LW : SW;

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      rsl_d   = rsl_q;
      nib_d   = nib_q;
      cnt_d   = cnt_q;
      ack_d   = 2'b00;
      en_d    = 1'b0;
      rs_d    = rs_q;
      data_d  = data_q;
`ifndef LCD_BUS_SCHED_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               byte_d     = win_byte;
               rsl_d      = bus.rs_in[win];
               nib_d      = bus.nib[win];
               ack_d[win] = 1'b1;
`ifndef LCD_BUS_SCHED_FIXED_PRIO_EN
               last_d     = win;
`endif
               state_d    = HI;
               en_d       = 1'b1;
               data_d     = win_byte[7:4];
               rs_d       = bus.rs_in[win];
            end
         end
         HI: state_d = HI_L;
         HI_L: begin
            if (nib_q) begin
               if (wait_n == 4'd0) state_d = IDLE;
               else begin
                  state_d = WAIT;
                  cnt_d   = wait_n;
               end
            end else begin
               state_d = LO;
               en_d    = 1'b1;
               data_d  = byte_q[3:0];
            end
         end
         LO: state_d = LO_L;
         LO_L: begin
            if (wait_n == 4'd0) state_d = IDLE;
            else begin
               state_d = WAIT;
               cnt_d   = wait_n;
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         byte_q  <= 8'h00;
         rsl_q   <= 1'b0;
         nib_q   <= 1'b0;
         cnt_q   <= 4'd0;
         ack_q   <= 2'b00;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 4'h0;
         busy_q  <= 1'b0;
`ifndef LCD_BUS_SCHED_FIXED_PRIO_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         rsl_q   <= rsl_d;
         nib_q   <= nib_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         en_q    <= en_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
`ifndef LCD_BUS_SCHED_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   assign bus.ack  = ack_q;
   assign bus.en   = en_q;
   assign bus.rs   = rs_q;
   assign bus.data = data_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed + random bench for lcd_bus_sched against a transfer-level output model.
module tb_lcd_bus_sched;
   localparam int SHORT_WAIT = 0;
   localparam int LONG_WAIT  = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   lcd_bus_sched_if bus();

   lcd_bus_sched #(.SHORT_WAIT(SHORT_WAIT), .LONG_WAIT(LONG_WAIT)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mode;                 // 0 hold req, 1 drop on ack, 2 random requesters
   logic [8:0] exp_q[$];     // {ack, en, rs, data, busy} per non-idle cycle
   logic cur_idle;
   logic last_w;
   logic [3:0] idle_data;
   logic idle_rs;
   logic [1:0] cur_ack;

   function automatic logic [8:0] obs();
      return {bus.ack, bus.en, bus.rs, bus.data, bus.busy};
   endfunction

   task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed={ack,en,rs,data,busy}=%h expected=%h", tag, o, e);
      end
   endtask

   function automatic void model_reset();
      exp_q.delete();
      cur_idle  = 1'b1;
      last_w    = 1'b1;
      idle_data = 4'h0;
      idle_rs   = 1'b0;
   endfunction

   function automatic logic [7:0] rnd_byte();
      if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 4));
      return 8'($urandom);
   endfunction

   // Expected outputs of one transfer, built from the bus protocol rules.
   task automatic grant();
      logic w, r, n;
      logic [7:0] b;
      logic [3:0] tail;
      int wt;
      if (bus.req == 2'b00) return;
`ifdef LCD_BUS_SCHED_FIXED_PRIO_EN
      w = bus.req[0] ? 1'b0 : 1'b1;
`else
      if (bus.req == 2'b11) w = ~last_w;
      else                  w = bus.req[0] ? 1'b0 : 1'b1;
`endif
      last_w = w;
      b = w ? bus.din1 : bus.din0;
      r = bus.rs_in[w];
      n = bus.nib[w];
      wt = (!r && !n && b >= 8'h01 && b <= 8'h03) ? LONG_WAIT : SHORT_WAIT;
      exp_q.push_back({(w ? 2'b10 : 2'b01), 1'b1, r, b[7:4], 1'b1});
      exp_q.push_back({2'b00, 1'b0, r, b[7:4], 1'b1});
      if (!n) begin
         exp_q.push_back({2'b00, 1'b1, r, b[3:0], 1'b1});
         exp_q.push_back({2'b00, 1'b0, r, b[3:0], 1'b1});
      end
      tail = n ? b[7:4] : b[3:0];
      for (int k = 0; k < wt; k++) exp_q.push_back({2'b00, 1'b0, r, tail, 1'b1});
      idle_data = tail;
      idle_rs   = r;
   endtask

   task automatic step(input string tag);
      logic [8:0] e;
      @(posedge clk);
      if (cur_idle) grant();
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cur_idle = 1'b0;
      end else begin
         e = {2'b00, 1'b0, idle_rs, idle_data, 1'b0};
         cur_idle = 1'b1;
      end
      check(tag, obs(), e);
      cur_ack = e[8:7];
      for (int i = 0; i < 2; i++) begin
         if (mode >= 1 && cur_ack[i]) bus.req[i] = 1'b0;
         if (mode == 2 && !bus.req[i]) begin
            if (i == 0) bus.din0 = rnd_byte();
            else        bus.din1 = rnd_byte();
            bus.nib[i]   = ($urandom_range(0, 3) == 0);
            bus.rs_in[i] = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) bus.req[i] = 1'b1;
         end
      end
   endtask

   initial begin
      bus.req = 2'b00; bus.nib = 2'b00; bus.rs_in = 2'b00;
      bus.din0 = 8'h00; bus.din1 = 8'h00;
      mode = 0; cur_ack = 2'b00;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset", obs(), 9'h000);
      reset_n = 1'b1;

      mode = 1;
      bus.din0 = 8'h28; bus.rs_in = 2'b00; bus.nib = 2'b00; bus.req = 2'b01;
      repeat (7) step("byte28");

      bus.din1 = 8'h30; bus.nib = 2'b10; bus.req = 2'b10;
      repeat (5) step("nib30");

      bus.nib = 2'b00; bus.din0 = 8'h01; bus.rs_in = 2'b00; bus.req = 2'b01;
      repeat (8) step("clr_rs0");
      bus.rs_in = 2'b01; bus.req = 2'b01;
      repeat (6) step("clr_rs1");

      mode = 0;
      bus.din0 = 8'hA5; bus.din1 = 8'h3C; bus.rs_in = 2'b11; bus.req = 2'b11;
      repeat (20) step("tie");
      bus.req = 2'b00;
      repeat (6) step("drain");

      bus.din0 = 8'h5A; bus.rs_in = 2'b00; bus.req = 2'b01;
      repeat (3) step("rst_pre");
      #2 reset_n = 1'b0;
      #1 check("rst_async", obs(), 9'h000);
      model_reset();
      @(negedge clk);
      check("rst_hold", obs(), 9'h000);
      reset_n = 1'b1;
      mode = 1;
      repeat (7) step("rst_restart");

      mode = 2;
      repeat (600) step("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
